// File: rtl/dmem_dump_reader_pkg.sv
// rtl/dmem_dump_reader_pkg.sv - shared widths, FSM state encoding and byte-lane helper for the data-memory dump reader
package dmem_dump_reader_pkg;

  localparam int DUMP_ADDR_W = 12;
  localparam int DUMP_DATA_W = 32;
  localparam int DUMP_CNT_W  = 11;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_FETCH = 2'd1,
    DUMP_SEND  = 2'd2,
    DUMP_FIN   = 2'd3
  } dump_state_e;

  // Little-endian byte lane select: lane 0 is the least significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/dmem_dump_reader_if.sv
// rtl/dmem_dump_reader_if.sv - BRAM debug read port plus byte-stream tx handshake of the dump reader
interface dmem_dump_reader_if
  import dmem_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
);

  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output dbg_addr,
    output tx_data,
    output tx_valid,
    input  dbg_data,
    input  tx_ready
  );

  modport slave (
    input  dbg_addr,
    input  tx_data,
    input  tx_valid,
    output dbg_data,
    output tx_ready
  );

endinterface

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - streams a word window of data BRAM out as little-endian bytes while stalling the core
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W,
  parameter int CNT_W  = DUMP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_stall,
  dmem_dump_reader_if.master    bus
);

  localparam int PTR_W = ADDR_W - 2;

  dump_state_e       state_q, state_d;
  logic [PTR_W-1:0]  word_ptr_q, word_ptr_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic [DATA_W-1:0] word_buf_q, word_buf_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;

  // Byte offset bits of base_addr are deliberately dropped; the window is word aligned.
  logic base_addr_unused;
  assign base_addr_unused = &base_addr[1:0];

  always_comb begin
    state_d      = state_q;
    word_ptr_d   = word_ptr_q;
    words_left_d = words_left_q;
    word_buf_d   = word_buf_q;
    byte_idx_d   = byte_idx_q;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d      = DUMP_FETCH;
            word_ptr_d   = base_addr[ADDR_W-1:2];
            words_left_d = word_count;
          end else begin
            state_d = DUMP_FIN;
          end
        end
      end
      DUMP_FETCH: begin
        word_buf_d = bus.dbg_data;
        byte_idx_d = 2'd0;
        state_d    = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (bus.tx_ready) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            words_left_d = words_left_q - CNT_W'(1);
            // word_ptr is exactly PTR_W bits, so this increment wraps at the top of the BRAM.
            word_ptr_d   = word_ptr_q + PTR_W'(1);
            state_d      = (words_left_q > CNT_W'(1)) ? DUMP_FETCH : DUMP_FIN;
          end
        end
      end
      DUMP_FIN: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
    tx_valid_d = (state_d == DUMP_SEND);
    done_d     = (state_q == DUMP_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= DUMP_IDLE;
      word_ptr_q   <= '0;
      words_left_q <= '0;
      word_buf_q   <= '0;
      byte_idx_q   <= 2'd0;
      tx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_ptr_q   <= word_ptr_d;
      words_left_q <= words_left_d;
      word_buf_q   <= word_buf_d;
      byte_idx_q   <= byte_idx_d;
      tx_valid_q   <= tx_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy         = (state_q != DUMP_IDLE);
  assign cpu_stall    = busy;
  assign done         = done_q;
  assign bus.dbg_addr = {word_ptr_q, 2'b00};
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = byte_sel(word_buf_q, byte_idx_q);

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - scoreboard bench for dmem_dump_reader with a behavioural data BRAM
module tb_dmem_dump_reader;
  import dmem_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done, cpu_stall;
  logic        tx_ready = 1'b1;
  logic        toggle_mode = 1'b0;
  logic [3:0]  ready_pat = 4'b1001;
  int          ready_idx = 0;

  logic [31:0] mem [0:1023];

  dmem_dump_reader_if bus ();

  dmem_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .cpu_stall  (cpu_stall),
    .bus        (bus)
  );

  assign bus.dbg_data = mem[bus.dbg_addr[11:2]];
  assign bus.tx_ready = tx_ready;

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          busy_cycles = 0;
  int          bytes_seen = 0;
  logic [7:0]  exp_q[$];
  int          lat_q[$];
  logic        hold_pending = 1'b0;
  logic [7:0]  hold_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      tx_ready = ready_pat[ready_idx % 4];
      ready_idx++;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      check("cpu_stall_eq_busy", {31'b0, cpu_stall}, {31'b0, busy});
      if (busy) busy_cycles++;
      if (hold_pending) begin
        check("tx_valid_held", {31'b0, bus.tx_valid}, 32'd1);
        check("tx_data_stable", {24'b0, bus.tx_data}, {24'b0, hold_data});
      end
      hold_pending = bus.tx_valid && !tx_ready;
      hold_data    = bus.tx_data;
      if (bus.tx_valid && tx_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
        end else begin
          check("tx_byte", {24'b0, bus.tx_data}, {24'b0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        if (lat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
        end else begin
          int lat;
          lat = lat_q.pop_front();
          if (lat >= 0) check("done_latency", cyc - start_cyc, lat);
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [11:0] base, input logic [10:0] cnt, input int lat);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    lat_q.push_back(lat);
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      tick();
      t++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected a pulse", name, t);
    end
    repeat (3) tick();
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] v1[8] = '{8'hCD, 8'hAB, 8'h34, 8'h12, 8'h01, 8'hEF, 8'h00, 8'h00};
    logic [7:0] v4[8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] v5[4] = '{8'h01, 8'hEF, 8'h00, 8'h00};
    int d0;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[12'h010 >> 2] = 32'h1234ABCD;
    mem[12'h014 >> 2] = 32'h0000EF01;
    mem[12'hFFC >> 2] = 32'hAABBCCDD;
    mem[12'h000 >> 2] = 32'h11223344;

    rst = 1'b0;
    repeat (3) tick();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_stall", {31'b0, cpu_stall}, 32'd0);
    check("reset_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check("reset_tx_data", {24'b0, bus.tx_data}, 32'd0);
    check("reset_dbg_addr", {20'b0, bus.dbg_addr}, 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // 1: two words, sink always ready
    foreach (v1[i]) exp_q.push_back(v1[i]);
    busy_cycles = 0;
    d0 = done_cnt;
    issue_start(12'h010, 11'd2, 11);
    check("t1_dbg_addr_fetch", {20'b0, bus.dbg_addr}, 32'h010);
    wait_done("t1", d0);
    check("t1_busy_cycles", busy_cycles, 11);

    // 2: sink ready pattern 1-0-0-1
    foreach (v1[i]) exp_q.push_back(v1[i]);
    toggle_mode = 1'b1;
    d0 = done_cnt;
    issue_start(12'h010, 11'd2, -1);
    wait_done("t2", d0);
    toggle_mode = 1'b0;
    repeat (2) tick();

    // 3: zero-length dump
    busy_cycles = 0;
    d0 = done_cnt;
    issue_start(12'h020, 11'd0, 1);
    wait_done("t3", d0);
    check("t3_busy_cycles", busy_cycles, 1);

    // 4: window wraps from the top of the BRAM to address 0
    foreach (v4[i]) exp_q.push_back(v4[i]);
    busy_cycles = 0;
    d0 = done_cnt;
    issue_start(12'hFFC, 11'd2, 11);
    wait_done("t4", d0);
    check("t4_busy_cycles", busy_cycles, 11);

    // 5: reset after the second byte, then a fresh dump
    foreach (v1[i]) exp_q.push_back(v1[i]);
    d0 = done_cnt;
    bytes_seen = 0;
    issue_start(12'h010, 11'd2, 11);
    begin
      int t;
      t = 0;
      while (bytes_seen < 2 && t < 50) begin
        tick();
        t++;
      end
      check("t5_bytes_before_reset", bytes_seen, 2);
    end
    rst = 1'b0;
    tick();
    check("t5_tx_valid_after_rst", {31'b0, bus.tx_valid}, 32'd0);
    check("t5_busy_after_rst", {31'b0, busy}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    rst = 1'b1;
    repeat (10) tick();
    check("t5_no_done", done_cnt - d0, 0);
    foreach (v5[i]) exp_q.push_back(v5[i]);
    busy_cycles = 0;
    issue_start(12'h014, 11'd1, 6);
    wait_done("t5b", d0);
    check("t5b_busy_cycles", busy_cycles, 6);

    // 6: a second start while busy is dropped
    foreach (v1[i]) exp_q.push_back(v1[i]);
    busy_cycles = 0;
    d0 = done_cnt;
    issue_start(12'h010, 11'd2, 11);
    repeat (3) tick();
    base_addr  = 12'h000;
    word_count = 11'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6", d0);
    repeat (20) tick();
    check("t6_single_done", done_cnt - d0, 1);
    check("t6_busy_cycles", busy_cycles, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
